// File: rtl/cache_refill_if.sv
// Bundle of the refill engine's handshake and bus signals: miss request from
// the cache FSM, read port to the backing RAM, data/tag write ports into the
// cache arrays, and the critical-byte forward path.
interface cache_refill_if #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 6,
  parameter int LINE_W = 2,
  parameter int BLK_W  = 3
);
  localparam int ADDR_W = TAG_W + LINE_W + BLK_W;

  // Miss request side
  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic              busy;
  logic              fill_done;

  // Backing RAM read port
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;

  // Data-cache write port
  logic              dwr;
  logic [LINE_W-1:0] dline;
  logic [BLK_W-1:0]  dblk;
  logic [DATA_W-1:0] ddata;

  // Tag store / valid-bit write port
  logic              twr;
  logic [TAG_W-1:0]  ttag;

  // Early-forwarded requested byte
  logic              crit_valid;
  logic [DATA_W-1:0] crit_data;

  // Cache FSM plus RAM side: issues misses, answers reads, observes writes
  modport master (
    output miss_req, miss_addr, mem_ack, mem_data,
    input  busy, fill_done, mem_req, mem_addr,
    input  dwr, dline, dblk, ddata, twr, ttag, crit_valid, crit_data
  );

  // Refill engine side
  modport slave (
    input  miss_req, miss_addr, mem_ack, mem_data,
    output busy, fill_done, mem_req, mem_addr,
    output dwr, dline, dblk, ddata, twr, ttag, crit_valid, crit_data
  );
endinterface

// File: rtl/cache_refill.sv
// Critical-word-first cache line refill engine. On a miss it fetches all
// 2**BLK_W beats of the line from the backing RAM starting at the missing
// block, wrapping around, writes each beat into the data array as it
// arrives, forwards the first (requested) byte immediately, and only then
// writes the tag/valid bit so an interrupted fill never leaves a valid line.
module cache_refill #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 6,
  parameter int LINE_W = 2,
  parameter int BLK_W  = 3
) (
  input  logic           clk,
  input  logic           reset,
  cache_refill_if.slave  bus
);

  localparam int ADDR_W = TAG_W + LINE_W + BLK_W;
  // Beat counter value on the final beat of a line
  localparam logic [BLK_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TAG_W-1:0]  tag_q,   tag_d;
  logic [LINE_W-1:0] line_q,  line_d;
  logic [BLK_W-1:0]  beat_q,  beat_d;
  logic [BLK_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] crit_q,  crit_d;

  logic              first_beat;
  logic              ack_in_fetch;

  // An ack only means something while the engine is fetching
  assign ack_in_fetch = (state_q == ST_FETCH) && bus.mem_ack;
  assign first_beat   = (cnt_q == '0);

  // Next-state and datapath update for the fill sequencer
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    line_d  = line_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    crit_d  = crit_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.miss_req) begin
          tag_d   = bus.miss_addr[ADDR_W-1 -: TAG_W];
          line_d  = bus.miss_addr[BLK_W +: LINE_W];
          beat_d  = bus.miss_addr[BLK_W-1:0];
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (ack_in_fetch) begin
          // Beat wraps naturally at the line boundary
          beat_d = beat_q + BLK_W'(1);
          cnt_d  = cnt_q + BLK_W'(1);
          if (first_beat) begin
            crit_d = bus.mem_data;
          end
          if (cnt_q == CNT_LAST) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; strobes are suppressed while reset is held so nothing
  // reaches the cache arrays from a state that is about to be discarded
  always_comb begin
    bus.busy       = 1'b0;
    bus.fill_done  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_addr   = {tag_q, line_q, beat_q};
    bus.dwr        = 1'b0;
    bus.dline      = line_q;
    bus.dblk       = beat_q;
    bus.ddata      = bus.mem_data;
    bus.twr        = 1'b0;
    bus.ttag       = tag_q;
    bus.crit_valid = 1'b0;
    bus.crit_data  = crit_q;
    if (!reset) begin
      bus.busy = (state_q != ST_IDLE);
      case (state_q)
        ST_FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ack) begin
            bus.dwr = 1'b1;
            if (first_beat) begin
              bus.crit_valid = 1'b1;
              bus.crit_data  = bus.mem_data;
            end
          end
        end
        ST_COMMIT: begin
          bus.twr = 1'b1;
        end
        ST_DONE: begin
          bus.fill_done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // State register; reset dominates any miss or ack in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      line_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      crit_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      crit_q  <= crit_d;
    end
  end

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: basic fill, blk=0 fill, ignored miss during
// FETCH, slow RAM, reset mid-fill, spurious ack in IDLE.
module tb_cache_refill;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cache_refill_if #(.DATA_W(8), .TAG_W(6), .LINE_W(2), .BLK_W(3)) bus ();

  cache_refill #(.DATA_W(8), .TAG_W(6), .LINE_W(2), .BLK_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // RAM model: the byte stored at each address is its low 8 address bits
  assign bus.mem_data = bus.mem_addr[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // All strobes low
  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_fill_done"},  32'(bus.fill_done),  32'd0);
    chk({tag, "_mem_req"},    32'(bus.mem_req),    32'd0);
    chk({tag, "_dwr"},        32'(bus.dwr),        32'd0);
    chk({tag, "_twr"},        32'(bus.twr),        32'd0);
    chk({tag, "_crit_valid"}, 32'(bus.crit_valid), 32'd0);
  endtask

  // One complete fill. Cycle 0 is the miss strobe. Each beat is preceded by
  // 'waits' cycles with mem_ack low. If poke_beat >= 0, a second miss with
  // poke_addr is strobed on the first cycle of that beat and must be ignored.
  task automatic run_fill(input logic [10:0] addr, input int waits,
                          input logic [10:0] poke_addr, input int poke_beat);
    logic [7:0]  tagline;
    logic [2:0]  beat;
    logic [10:0] exp_addr;
    logic [7:0]  crit;
    int          cyc;
    tagline = addr[10:3];
    beat    = addr[2:0];
    crit    = 8'h00;
    @(negedge clk);
    bus.miss_req  = 1'b1;
    bus.miss_addr = addr;
    bus.mem_ack   = 1'b0;
    #1;
    chk("accept_busy", 32'(bus.busy), 32'd0);
    chk("accept_mem_req", 32'(bus.mem_req), 32'd0);
    cyc = 0;
    for (int n = 0; n < 8; n++) begin
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        cyc++;
        bus.miss_req  = (n == poke_beat) && (w == 0);
        bus.miss_addr = bus.miss_req ? poke_addr : addr;
        bus.mem_ack   = (w == waits);
        #1;
        exp_addr = {tagline, beat};
        chk("fetch_busy", 32'(bus.busy), 32'd1);
        chk("fetch_mem_req", 32'(bus.mem_req), 32'd1);
        chk("fetch_mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        chk("fetch_dwr", 32'(bus.dwr), 32'(bus.mem_ack));
        chk("fetch_twr", 32'(bus.twr), 32'd0);
        chk("fetch_fill_done", 32'(bus.fill_done), 32'd0);
        if (w == waits) begin
          chk("beat_dblk", 32'(bus.dblk), 32'(beat));
          chk("beat_dline", 32'(bus.dline), 32'(addr[4:3]));
          chk("beat_ddata", 32'(bus.ddata), 32'(exp_addr[7:0]));
          chk("beat_crit_valid", 32'(bus.crit_valid), (n == 0) ? 32'd1 : 32'd0);
          if (n == 0) crit = exp_addr[7:0];
          chk("beat_crit_data", 32'(bus.crit_data), 32'(crit));
        end else begin
          chk("wait_crit_valid", 32'(bus.crit_valid), 32'd0);
        end
      end
      beat = beat + 3'd1;
    end
    // COMMIT
    @(negedge clk);
    cyc++;
    bus.miss_req = 1'b0;
    bus.mem_ack  = 1'b0;
    #1;
    chk("commit_twr", 32'(bus.twr), 32'd1);
    chk("commit_ttag", 32'(bus.ttag), 32'(addr[10:5]));
    chk("commit_mem_req", 32'(bus.mem_req), 32'd0);
    chk("commit_dwr", 32'(bus.dwr), 32'd0);
    chk("commit_fill_done", 32'(bus.fill_done), 32'd0);
    chk("commit_busy", 32'(bus.busy), 32'd1);
    chk("commit_crit_hold", 32'(bus.crit_data), 32'(crit));
    // DONE
    @(negedge clk);
    cyc++;
    #1;
    chk("done_fill_done", 32'(bus.fill_done), 32'd1);
    chk("done_twr", 32'(bus.twr), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd1);
    chk("done_mem_req", 32'(bus.mem_req), 32'd0);
    $display("fill addr=0x%03h waits=%0d crit=0x%02h fill_done at cycle %0d", addr, waits, crit, cyc);
    // Back in IDLE; nothing queued from an ignored miss
    repeat (2) begin
      @(negedge clk);
      #1;
      chk_quiet("post_idle");
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.miss_req  = 1'b0;
    bus.miss_addr = '0;
    bus.mem_ack   = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_crit_data", 32'(bus.crit_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_quiet("after_reset");

    // Basic fill: tag 0x15, line 1, blk 5 -> beats 5,6,7,0..4, crit 0xAD,
    // twr at cycle 9, fill_done at 10, idle again at 11
    run_fill(11'h2AD, 0, 11'h000, -1);

    // blk = 0: tag 0x07, line 2 -> beats 0..7, crit on beat 0
    run_fill(11'h0F0, 0, 11'h000, -1);

    // Miss strobed mid-FETCH with a different address is ignored
    run_fill(11'h1B3, 0, 11'h7FF, 2);

    // Slow RAM: one cycle to register the address plus three wait cycles
    // before every ack, so each beat takes 5 cycles and fill_done lands at 42
    run_fill(11'h3C6, 4, 11'h000, -1);

    // Reset after the 4th ack of a fill
    @(negedge clk);
    bus.miss_req  = 1'b1;
    bus.miss_addr = 11'h155;
    bus.mem_ack   = 1'b1;
    #1;
    chk("rst_mid_accept_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.miss_req = 1'b0;
      #1;
      chk("rst_mid_dwr", 32'(bus.dwr), 32'd1);
    end
    @(negedge clk);
    reset        = 1'b1;
    bus.miss_req = 1'b1;
    bus.mem_ack  = 1'b1;
    #1;
    chk_quiet("rst_mid_during");
    @(negedge clk);
    reset        = 1'b0;
    bus.miss_req = 1'b0;
    bus.mem_ack  = 1'b0;
    #1;
    chk_quiet("rst_mid_after");
    chk("rst_mid_crit_data", 32'(bus.crit_data), 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk_quiet("rst_mid_no_commit");
    end
    $display("fill addr=0x155 aborted by reset after 4 beats");

    // Spurious acks in IDLE
    repeat (3) begin
      @(negedge clk);
      bus.mem_ack = 1'b1;
      #1;
      chk_quiet("spurious_ack");
    end
    $display("spurious mem_ack in IDLE for 3 cycles");

    // A normal fill after the aborted one
    run_fill(11'h155, 0, 11'h000, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
